// File: rtl/ex_stage.sv
// Execute stage: ALU, Z/N flags, branch/jump resolution and the EX/MEM register,
// with a down-counter that squashes the wrong-path instructions behind a taken transfer.
module ex_stage #(
    parameter int SQUASH_SLOTS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        stall,
    input  logic        branch_z,
    input  logic        branch_n,
    input  logic        jump,
    input  logic        jump_mem,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_to_reg,
    input  logic        reg_wrt,
    input  logic        alu_src,
    input  logic        svpc,
    input  logic        add,
    input  logic        sub,
    input  logic        inc,
    input  logic        neg,
    input  logic [31:0] imm,
    input  logic [5:0]  rd,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic [31:0] pc,
    output logic        out_valid,
    output logic [31:0] alu_result,
    output logic [31:0] store_data,
    output logic [5:0]  rd_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic        mem_to_reg_out,
    output logic        reg_wrt_out,
    output logic        jump_mem_out,
    output logic        flag_z,
    output logic        flag_n,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        squash_active
);

    localparam logic [2:0] SquashLoad = 3'(SQUASH_SLOTS);

    logic [2:0]  squashCnt;
    logic [31:0] opB;
    logic [31:0] aluRes;
    logic        accept;
    logic        taken;
    logic        flagOp;

    assign opB = alu_src ? imm : rs2_val;

    always_comb begin
        aluRes = rs1_val;
        if (svpc)     aluRes = pc + imm;
        else if (add) aluRes = rs1_val + opB;
        else if (sub) aluRes = rs1_val - opB;
        else if (inc) aluRes = rs1_val + 32'd1;
        else if (neg) aluRes = 32'd0 - rs1_val;
    end

    assign accept = in_valid & ~stall & (squashCnt == 3'd0);
    assign flagOp = add | sub | inc | neg;
    // Branches see the flags from the previous ALU op, not this instruction's result.
    assign taken  = accept & (jump | jump_mem | (branch_z & flag_z) | (branch_n & flag_n));
    assign squash_active = (squashCnt != 3'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            alu_result     <= '0;
            store_data     <= '0;
            rd_out         <= '0;
            mem_read_out   <= 1'b0;
            mem_write_out  <= 1'b0;
            mem_to_reg_out <= 1'b0;
            reg_wrt_out    <= 1'b0;
            jump_mem_out   <= 1'b0;
            flag_z         <= 1'b0;
            flag_n         <= 1'b0;
            redirect       <= 1'b0;
            redirect_pc    <= '0;
            squashCnt      <= '0;
        end else if (stall) begin
            redirect <= 1'b0;
        end else begin
            redirect       <= taken & ~jump_mem;
            out_valid      <= accept;
            mem_read_out   <= accept & mem_read;
            mem_write_out  <= accept & mem_write;
            mem_to_reg_out <= accept & mem_to_reg;
            reg_wrt_out    <= accept & reg_wrt;
            jump_mem_out   <= accept & jump_mem;
            if (accept) begin
                alu_result <= aluRes;
                store_data <= rs2_val;
                rd_out     <= rd;
                if (flagOp) begin
                    flag_z <= (aluRes == 32'd0);
                    flag_n <= aluRes[31];
                end
            end
            if (taken) begin
                squashCnt   <= SquashLoad;
                redirect_pc <= rs1_val;
            end else if (in_valid && squashCnt != 3'd0) begin
                squashCnt <= squashCnt - 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage: ALU ops, flags, branch/jump redirect,
// squash counting, stall freeze and asynchronous reset mid-squash.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, stall, branch_z, branch_n, jump, jump_mem;
    logic        mem_read, mem_write, mem_to_reg, reg_wrt, alu_src;
    logic        svpc, add, sub, inc, neg;
    logic [31:0] imm, rs1_val, rs2_val, pc;
    logic [5:0]  rd;
    logic        out_valid, mem_read_out, mem_write_out, mem_to_reg_out, reg_wrt_out;
    logic        jump_mem_out, flag_z, flag_n, redirect, squash_active;
    logic [31:0] alu_result, store_data, redirect_pc;
    logic [5:0]  rd_out;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    ex_stage #(.SQUASH_SLOTS(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall),
        .branch_z(branch_z), .branch_n(branch_n), .jump(jump), .jump_mem(jump_mem),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .reg_wrt(reg_wrt), .alu_src(alu_src), .svpc(svpc), .add(add), .sub(sub),
        .inc(inc), .neg(neg), .imm(imm), .rd(rd), .rs1_val(rs1_val),
        .rs2_val(rs2_val), .pc(pc), .out_valid(out_valid), .alu_result(alu_result),
        .store_data(store_data), .rd_out(rd_out), .mem_read_out(mem_read_out),
        .mem_write_out(mem_write_out), .mem_to_reg_out(mem_to_reg_out),
        .reg_wrt_out(reg_wrt_out), .jump_mem_out(jump_mem_out), .flag_z(flag_z),
        .flag_n(flag_n), .redirect(redirect), .redirect_pc(redirect_pc),
        .squash_active(squash_active)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clearIn();
        in_valid = 0; stall = 0; branch_z = 0; branch_n = 0; jump = 0; jump_mem = 0;
        mem_read = 0; mem_write = 0; mem_to_reg = 0; reg_wrt = 0; alu_src = 0;
        svpc = 0; add = 0; sub = 0; inc = 0; neg = 0;
        imm = 0; rd = 0; rs1_val = 0; rs2_val = 0; pc = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clearIn();
        rst_n = 0;
        repeat (2) step();
        checkVal("rst_valid", out_valid, 0);
        checkVal("rst_alu", alu_result, 0);
        checkVal("rst_flags", {flag_z, flag_n}, 0);
        checkVal("rst_redir", redirect, 0);
        checkVal("rst_squash", squash_active, 0);
        rst_n = 1;

        // 1: add 5+7
        clearIn(); in_valid = 1; add = 1; rs1_val = 5; rs2_val = 7; rd = 6'd3; reg_wrt = 1;
        step();
        checkVal("add_valid", out_valid, 1);
        checkVal("add_res", alu_result, 12);
        checkVal("add_flags", {flag_z, flag_n}, 2'b00);
        checkVal("add_rd", rd_out, 3);
        checkVal("add_regwrt", reg_wrt_out, 1);
        checkVal("add_store", store_data, 7);

        // 2: sub 3-3 then BRZ to 0x40, two wrong-path drops
        clearIn(); in_valid = 1; sub = 1; rs1_val = 3; rs2_val = 3;
        step();
        checkVal("sub_res", alu_result, 0);
        checkVal("sub_z", flag_z, 1);
        clearIn(); in_valid = 1; branch_z = 1; rs1_val = 32'h40;
        step();
        checkVal("brz_redir", redirect, 1);
        checkVal("brz_pc", redirect_pc, 32'h40);
        checkVal("brz_squash", squash_active, 1);
        clearIn(); in_valid = 1; add = 1; rs1_val = 1; rs2_val = 1; reg_wrt = 1;
        step();
        checkVal("drop1_valid", out_valid, 0);
        checkVal("drop1_regwrt", reg_wrt_out, 0);
        checkVal("drop1_redir", redirect, 0);
        checkVal("drop1_squash", squash_active, 1);
        checkVal("drop1_flagz", flag_z, 1);
        clearIn();
        step();
        checkVal("bubble_squash", squash_active, 1);
        in_valid = 1; add = 1; rs1_val = 1; rs2_val = 1;
        step();
        checkVal("drop2_valid", out_valid, 0);
        checkVal("drop2_squash", squash_active, 0);
        step();
        checkVal("post_valid", out_valid, 1);
        checkVal("post_res", alu_result, 2);
        checkVal("post_z", flag_z, 0);

        // 3: neg 1, BRZ not taken, BRN taken
        clearIn(); in_valid = 1; neg = 1; rs1_val = 1;
        step();
        checkVal("neg_res", alu_result, 32'hFFFF_FFFF);
        checkVal("neg_flags", {flag_z, flag_n}, 2'b01);
        clearIn(); in_valid = 1; branch_z = 1; rs1_val = 32'h100;
        step();
        checkVal("brz_nt_redir", redirect, 0);
        checkVal("brz_nt_squash", squash_active, 0);
        checkVal("brz_nt_valid", out_valid, 1);
        clearIn(); in_valid = 1; branch_n = 1; rs1_val = 32'h200;
        step();
        checkVal("brn_redir", redirect, 1);
        checkVal("brn_pc", redirect_pc, 32'h200);

        // 4: stall for 3 cycles with counter at 2
        clearIn(); in_valid = 1; stall = 1; add = 1; rs1_val = 9; rs2_val = 9;
        for (int i = 0; i < 3; i++) begin
            step();
            checkVal("stall_redir", redirect, 0);
            checkVal("stall_valid", out_valid, 1);
            checkVal("stall_res", alu_result, 32'h200);
            checkVal("stall_squash", squash_active, 1);
        end
        stall = 0;
        step();
        checkVal("unstall_drop1", squash_active, 1);
        checkVal("unstall_valid", out_valid, 0);
        step();
        checkVal("unstall_drop2", squash_active, 0);

        // 5: jump_mem to 0x80
        clearIn(); in_valid = 1; jump_mem = 1; mem_read = 1; rs1_val = 32'h80;
        step();
        checkVal("jm_redir", redirect, 0);
        checkVal("jm_out", jump_mem_out, 1);
        checkVal("jm_res", alu_result, 32'h80);
        checkVal("jm_memrd", mem_read_out, 1);
        checkVal("jm_squash", squash_active, 1);
        clearIn(); in_valid = 1; add = 1;
        step();
        checkVal("jm_drop_out", jump_mem_out, 0);
        checkVal("jm_drop_squash", squash_active, 1);

        // 6: async reset with counter at 1
        rst_n = 0;
        #1;
        checkVal("arst_squash", squash_active, 0);
        checkVal("arst_valid", out_valid, 0);
        checkVal("arst_rpc", redirect_pc, 0);
        checkVal("arst_flags", {flag_z, flag_n}, 0);
        #2 rst_n = 1;
        clearIn(); in_valid = 1; add = 1; rs1_val = 2; rs2_val = 3;
        step();
        checkVal("arst_next_valid", out_valid, 1);
        checkVal("arst_next_res", alu_result, 5);

        // J redirect pulse, then reset clears the pending squash and redirect
        clearIn(); in_valid = 1; jump = 1; rs1_val = 32'h300;
        step();
        checkVal("j_redir", redirect, 1);
        checkVal("j_pc", redirect_pc, 32'h300);
        clearIn();
        step();
        checkVal("j_pulse_end", redirect, 0);
        rst_n = 0;
        #2 rst_n = 1;
        checkVal("j_rst_squash", squash_active, 0);

        // Immediate operand, svpc priority, inc wrap
        clearIn(); in_valid = 1; add = 1; alu_src = 1; rs1_val = 10; rs2_val = 99; imm = 32'hFFFF_FFFD;
        step();
        checkVal("addi_res", alu_result, 7);
        clearIn(); in_valid = 1; svpc = 1; add = 1; pc = 32'h1000; imm = 8; rs1_val = 1; rs2_val = 1;
        step();
        checkVal("svpc_res", alu_result, 32'h1008);
        clearIn(); in_valid = 1; inc = 1; rs1_val = 32'hFFFF_FFFF;
        step();
        checkVal("inc_res", alu_result, 0);
        checkVal("inc_flags", {flag_z, flag_n}, 2'b10);
        clearIn(); in_valid = 1; sub = 1; alu_src = 1; rs1_val = 4; imm = 6;
        step();
        checkVal("subi_res", alu_result, 32'hFFFF_FFFE);
        checkVal("subi_flags", {flag_z, flag_n}, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
